motor_cmd_arbiter: RTL and testbench
====================================

MOTOR_CMD_ARBITER -- requirements
Module: motor_cmd_arbiter

Interface
REQ-001 Parameter NUM_SRC, 2: number of motor-command sources; legal range 2..4.
REQ-002 Parameter TIMEOUT_CYC, 25000000: idle cycles after the last strobe before a source is stale (250 ms at 100 MHz).
REQ-003 Parameter DEADTIME_CYC, 100000: zero-drive cycles inserted on a direction reversal (1 ms).
REQ-004 clk  input  1  100 MHz system clock; all state on rising edge.
REQ-005 btnCpuReset  input  1  asynchronous, active-low reset.
REQ-006 src_cmd  input  8*NUM_SRC  packed commands; source i at [8i+7:8i]; left dir field [5:4], right dir field [1:0].
REQ-007 src_valid  input  NUM_SRC  one-cycle load strobe per source.
REQ-008 mode  input  1  0 = manual (sel_src picks the source), 1 = priority (highest-index fresh source wins).
REQ-009 sel_src  input  2  manual-mode source index.
REQ-010 motctl  output  8  registered drive command to the motor driver.
REQ-011 active_src  output  2  registered index of the source currently selected.
REQ-012 failsafe  output  1  high while in STOP.
REQ-013 dead_active  output  1  high while in DEAD.
REQ-014 src_fresh  output  NUM_SRC  per-source freshness flags.

Function
REQ-015 A src_valid[i] strobe shall load src_cmd slice i into hold register i, clear watchdog i and set src_fresh[i] on the next edge.
REQ-016 Watchdog i shall increment each cycle while src_fresh[i]=1; src_fresh[i] shall clear once TIMEOUT_CYC cycles pass with no strobe, and the counter shall then saturate.
REQ-017 A strobe in the same cycle as a timeout shall win: the source stays fresh.
REQ-018 Candidate: manual mode uses sel_src; priority mode uses the highest fresh index. The candidate is invalid if manual sel_src >= NUM_SRC, if the selected source is stale, or if no source is fresh in priority mode.
REQ-019 The FSM shall have exactly three states: STOP, RUN and DEAD.
REQ-020 STOP: motctl=0 and failsafe=1. On a valid candidate, go to RUN, register active_src, and drive hold[candidate] on the next edge.
REQ-021 RUN: motctl tracks hold[active_src]. Latency from src_valid to motctl is exactly 2 cycles. If the candidate becomes invalid, go to STOP on the next edge.
REQ-022 Reversal: a left or right field changing between 2'b10 and 2'b01 between the current motctl and the next candidate command. When DEADTIME is compiled in, a reversal shall move RUN to DEAD.
REQ-023 DEAD: motctl=0; the counter loads DEADTIME_CYC-1 and decrements. At zero, go to RUN and drive the current hold[candidate].
REQ-024 In DEAD, an invalid candidate shall go to STOP immediately, and a new reversal shall not restart the counter.
REQ-025 A candidate change (active_src update) without reversal shall take effect in one cycle with no zero-drive gap.
REQ-026 Counter widths shall be $clog2 of the parameter value plus 1. No counter shall wrap.

Reset
REQ-027 While btnCpuReset=0: state=STOP, motctl=8'h00, active_src=0, failsafe=1, dead_active=0, src_fresh=0, all hold registers=0, all counters=0.
REQ-028 Reset asserted mid-DEAD or mid-RUN shall force STOP asynchronously. Reset release shall be synchronised to clk through 2 flops before state may leave STOP.

Configuration
REQ-029 Macro MOTCTL_DEADTIME_EN defined: reversal handling per REQ-022..REQ-024.
REQ-030 Macro MOTCTL_DEADTIME_EN undefined: reversals behave as REQ-025, DEAD is unreachable, dead_active is tied 0, and no DEAD counter is synthesised.

Verification (bench: NUM_SRC=2, TIMEOUT_CYC=16, DEADTIME_CYC=4)
REQ-031 Reset release, mode=0, sel_src=0, strobe src0=8'h12 -> motctl=8'h12 two cycles after the strobe; failsafe drops.
REQ-032 Strobe src0=8'h22, then no further strobes -> motctl=8'h00 and failsafe=1 after 16 idle cycles; a strobe on cycle 16 keeps RUN.
REQ-033 Motctl=8'h22, then strobe 8'h11 -> 4 cycles of motctl=0 with dead_active=1, then 8'h11. With the macro off -> 8'h11 immediately.
REQ-034 Mode=1, src0 fresh with 8'h20, then strobe src1=8'h02 -> active_src=1 and motctl=8'h02. Src1 then times out -> active_src=0 and motctl=8'h20.
REQ-035 btnCpuReset pulsed low during DEAD -> motctl=0 and failsafe=1 asynchronously; all src_fresh=0 after release.
REQ-036 Mode=0, sel_src=3 -> STOP regardless of strobes.

Source files
------------

// File: rtl/motor_cmd_arbiter_if.sv
// Command-source and motor-drive signal bundle for motor_cmd_arbiter.
// The arbiter takes the slave side; whatever feeds the sources takes the master side.
interface motor_cmd_arbiter_if #(
    parameter int NUM_SRC = 2
);
    logic [8*NUM_SRC-1:0] src_cmd;
    logic [NUM_SRC-1:0]   src_valid;
    logic                 mode;
    logic [1:0]           sel_src;
    logic [7:0]           motctl;
    logic [1:0]           active_src;
    logic                 failsafe;
    logic                 dead_active;
    logic [NUM_SRC-1:0]   src_fresh;

    modport master (
        output src_cmd, src_valid, mode, sel_src,
        input  motctl, active_src, failsafe, dead_active, src_fresh
    );

    modport slave (
        input  src_cmd, src_valid, mode, sel_src,
        output motctl, active_src, failsafe, dead_active, src_fresh
    );
endinterface

// File: rtl/motor_cmd_arbiter.sv
// Motor command arbiter: per-source hold/watchdog, STOP/RUN/DEAD drive FSM.
// Define MOTCTL_DEADTIME_EN to insert a zero-drive gap on direction reversals.
module motor_cmd_arbiter #(
    parameter int NUM_SRC      = 2,
    parameter int TIMEOUT_CYC  = 25000000,
    parameter int DEADTIME_CYC = 100000
) (
    input  logic               clk,
    input  logic               btnCpuReset,
    motor_cmd_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DEAD} state_t;

    if (NUM_SRC < 2 || NUM_SRC > 4 || TIMEOUT_CYC < 1 || DEADTIME_CYC < 1) begin : g_bad_param
        $error("motor_cmd_arbiter: parameter out of range");
    end

    logic [1:0] rst_sync_reg;
    logic       run_ok;
    logic [7:0] hold4 [4];
    logic [3:0] fresh4;
    state_t     state_reg;
    logic [7:0] motctl_reg;
    logic [1:0] active_src_reg;
    logic       failsafe_reg;
    logic [1:0] cand_idx;
    logic       cand_valid;
    logic [7:0] cand_cmd;

    // Reset release is retimed so the FSM never leaves STOP on a metastable release.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) rst_sync_reg <= '0;
        else              rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign run_ok = rst_sync_reg[1];

    // Unused slots read as stale/zero so a 2-bit index is always safe.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_live
                logic [7:0]      hold_reg;
                logic [WD_W-1:0] wdog_reg;
                logic            fresh_reg;
                always_ff @(posedge clk or negedge btnCpuReset) begin
                    if (!btnCpuReset) begin
                        hold_reg  <= '0;
                        wdog_reg  <= '0;
                        fresh_reg <= 1'b0;
                    end else if (bus.src_valid[gi]) begin
                        hold_reg  <= bus.src_cmd[8*gi +: 8];
                        wdog_reg  <= '0;
                        fresh_reg <= 1'b1;
                    end else if (fresh_reg) begin
                        wdog_reg <= wdog_reg + 1'b1;
                        if (wdog_reg == WD_W'(TIMEOUT_CYC - 1)) fresh_reg <= 1'b0;
                    end
                end
                assign hold4[gi]  = hold_reg;
                assign fresh4[gi] = fresh_reg;
            end else begin : g_pad
                assign hold4[gi]  = '0;
                assign fresh4[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        cand_idx   = '0;
        cand_valid = 1'b0;
        if (bus.mode) begin
            for (int i = 0; i < 4; i++) begin
                if (fresh4[i]) begin
                    cand_idx   = 2'(i);
                    cand_valid = 1'b1;
                end
            end
        end else begin
            cand_idx   = bus.sel_src;
            cand_valid = fresh4[bus.sel_src];
        end
        cand_cmd = hold4[cand_idx];
    end

`ifdef MOTCTL_DEADTIME_EN
    localparam int DT_W = $clog2(DEADTIME_CYC) + 1;

    logic [DT_W-1:0] dead_cnt_reg;
    logic            dead_active_reg;
    logic            rev_hit;

    function automatic logic is_rev(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b10);
    endfunction

    assign rev_hit = is_rev(motctl_reg[5:4], cand_cmd[5:4]) || is_rev(motctl_reg[1:0], cand_cmd[1:0]);
    assign bus.dead_active = dead_active_reg;
`else
    assign bus.dead_active = 1'b0;
`endif

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_reg      <= ST_STOP;
            motctl_reg     <= '0;
            active_src_reg <= '0;
            failsafe_reg   <= 1'b1;
`ifdef MOTCTL_DEADTIME_EN
            dead_active_reg <= 1'b0;
            dead_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_STOP: begin
                    if (run_ok && cand_valid) begin
                        state_reg      <= ST_RUN;
                        motctl_reg     <= cand_cmd;
                        active_src_reg <= cand_idx;
                        failsafe_reg   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!cand_valid) begin
                        state_reg    <= ST_STOP;
                        motctl_reg   <= '0;
                        failsafe_reg <= 1'b1;
`ifdef MOTCTL_DEADTIME_EN
                    end else if (rev_hit) begin
                        state_reg       <= ST_DEAD;
                        motctl_reg      <= '0;
                        dead_active_reg <= 1'b1;
                        dead_cnt_reg    <= DT_W'(DEADTIME_CYC - 1);
`endif
                    end else begin
                        motctl_reg     <= cand_cmd;
                        active_src_reg <= cand_idx;
                    end
                end
`ifdef MOTCTL_DEADTIME_EN
                ST_DEAD: begin
                    if (!cand_valid) begin
                        state_reg       <= ST_STOP;
                        motctl_reg      <= '0;
                        failsafe_reg    <= 1'b1;
                        dead_active_reg <= 1'b0;
                    end else if (dead_cnt_reg == '0) begin
                        state_reg       <= ST_RUN;
                        motctl_reg      <= cand_cmd;
                        active_src_reg  <= cand_idx;
                        dead_active_reg <= 1'b0;
                    end else begin
                        dead_cnt_reg <= dead_cnt_reg - 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg    <= ST_STOP;
                    motctl_reg   <= '0;
                    failsafe_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.motctl     = motctl_reg;
    assign bus.active_src = active_src_reg;
    assign bus.failsafe   = failsafe_reg;
    assign bus.src_fresh  = fresh4[NUM_SRC-1:0];
endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Bench for motor_cmd_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_motor_cmd_arbiter;
    localparam int NSRC = 2;
    localparam int TO   = 16;
    localparam int DT   = 4;
`ifdef MOTCTL_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    motor_cmd_arbiter_if #(.NUM_SRC(NSRC)) bus ();

    motor_cmd_arbiter #(
        .NUM_SRC(NSRC), .TIMEOUT_CYC(TO), .DEADTIME_CYC(DT)
    ) dut (
        .clk(clk), .btnCpuReset(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model: per-source age since last strobe, plus drive value and remaining gap length.
    logic [7:0] m_hold [NSRC];
    int         m_age  [NSRC];
    bit         m_fresh[NSRC];
    logic [7:0] m_mot;
    int         m_src;
    bit         m_fs;
    int         m_gap;
    int         m_since;

    function automatic bit rev2(input logic [1:0] a, input logic [1:0] b);
        return ((a ^ b) == 2'b11) && (a != 2'b00) && (b != 2'b00);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_hold[i] = 8'h00; m_age[i] = 0; m_fresh[i] = 1'b0;
        end
        m_mot = 8'h00; m_src = 0; m_fs = 1'b1; m_gap = 0; m_since = 0;
    endtask

    task automatic m_step();
        bit ready, cv;
        int c;
        logic [7:0] cc;
        ready = (m_since >= 2);
        if (m_since < 2) m_since++;
        cv = 1'b0; c = 0;
        if (bus.mode) begin
            for (int i = 0; i < NSRC; i++) if (m_fresh[i]) begin c = i; cv = 1'b1; end
        end else if (int'(bus.sel_src) < NSRC) begin
            c = int'(bus.sel_src); cv = m_fresh[c];
        end
        cc = m_hold[c];
        if (m_fs) begin
            if (ready && cv) begin m_fs = 1'b0; m_mot = cc; m_src = c; end
        end else if (!cv) begin
            m_fs = 1'b1; m_mot = 8'h00; m_gap = 0;
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin m_mot = cc; m_src = c; end
        end else if (DT_EN && (rev2(m_mot[5:4], cc[5:4]) || rev2(m_mot[1:0], cc[1:0]))) begin
            m_gap = DT; m_mot = 8'h00;
        end else begin
            m_mot = cc; m_src = c;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (bus.src_valid[i]) begin
                m_hold[i] = bus.src_cmd[8*i +: 8]; m_age[i] = 0; m_fresh[i] = 1'b1;
            end else if (m_fresh[i]) begin
                m_age[i]++;
                if (m_age[i] >= TO) m_fresh[i] = 1'b0;
            end
        end
    endtask

    initial m_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Every clock goes through here so the model comparison runs on all cycles.
    task automatic step();
        logic [NSRC-1:0] mf;
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < NSRC; i++) mf[i] = m_fresh[i];
            n_checks++;
            if (bus.motctl === m_mot && bus.active_src === 2'(m_src) && bus.failsafe === m_fs &&
                bus.dead_active === (m_gap > 0) && bus.src_fresh === mf) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_model t=%0t: dut mot=%h src=%0d fs=%b dead=%b fresh=%b, model mot=%h src=%0d fs=%b dead=%b fresh=%b",
                         $time, bus.motctl, bus.active_src, bus.failsafe, bus.dead_active, bus.src_fresh,
                         m_mot, m_src, m_fs, (m_gap > 0), mf);
            end
        end
    endtask

    task automatic strobe(input int i, input logic [7:0] cmd);
        $display("strobe src%0d cmd=%h t=%0t", i, cmd, $time);
        bus.src_cmd[8*i +: 8] = cmd;
        bus.src_valid[i]      = 1'b1;
        step();
        bus.src_valid = '0;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        bus.src_cmd = '0; bus.src_valid = '0; bus.mode = 1'b0; bus.sel_src = 2'd0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        step();
        chk("rst_motctl", bus.motctl, 8'h00);
        chk("rst_failsafe", 8'(bus.failsafe), 8'h01);
        chk("rst_dead", 8'(bus.dead_active), 8'h00);
        chk("rst_fresh", 8'(bus.src_fresh), 8'h00);
        chk("rst_active", 8'(bus.active_src), 8'h00);
        release_rst();

        // First command: two-cycle latency.
        strobe(0, 8'h12);
        chk("lat_not_yet", bus.motctl, 8'h00);
        step();
        chk("lat_motctl", bus.motctl, 8'h12);
        chk("lat_failsafe", 8'(bus.failsafe), 8'h00);

        // Timeout without refresh.
        strobe(0, 8'h22);
        step();
        chk("to_run", bus.motctl, 8'h22);
        repeat (14) step();
        chk("to_fresh15", 8'(bus.src_fresh), 8'h01);
        step();
        chk("to_fresh16", 8'(bus.src_fresh), 8'h00);
        chk("to_mot16", bus.motctl, 8'h22);
        step();
        chk("to_stop_mot", bus.motctl, 8'h00);
        chk("to_stop_fs", 8'(bus.failsafe), 8'h01);

        // Strobe coincident with the timeout keeps RUN.
        strobe(0, 8'h22);
        repeat (15) step();
        strobe(0, 8'h22);
        step();
        chk("to_race_fs", 8'(bus.failsafe), 8'h00);
        chk("to_race_mot", bus.motctl, 8'h22);
        chk("to_race_fresh", 8'(bus.src_fresh), 8'h01);

        // Reversal 22 -> 11.
        strobe(0, 8'h11);
        chk("rev_hold_old", bus.motctl, 8'h22);
        step();
`ifdef MOTCTL_DEADTIME_EN
        chk("rev_dead_mot", bus.motctl, 8'h00);
        chk("rev_dead_flag", 8'(bus.dead_active), 8'h01);
        repeat (3) step();
        chk("rev_dead_last", bus.motctl, 8'h00);
        chk("rev_dead_last_flag", 8'(bus.dead_active), 8'h01);
        step();
        chk("rev_after_mot", bus.motctl, 8'h11);
        chk("rev_after_flag", 8'(bus.dead_active), 8'h00);
`else
        chk("rev_direct_mot", bus.motctl, 8'h11);
        chk("rev_direct_flag", 8'(bus.dead_active), 8'h00);
        repeat (4) step();
`endif

        // Async reset during the reversal gap.
        strobe(0, 8'h22);
        step();
`ifdef MOTCTL_DEADTIME_EN
        chk("arst_in_dead", 8'(bus.dead_active), 8'h01);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mot", bus.motctl, 8'h00);
        chk("arst_fs", 8'(bus.failsafe), 8'h01);
        chk("arst_dead", 8'(bus.dead_active), 8'h00);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_fresh", 8'(bus.src_fresh), 8'h00);
        repeat (3) step();

        // Priority mode: higher index wins, then falls back on its timeout.
        bus.mode = 1'b1;
        strobe(0, 8'h20);
        step();
        chk("pri_src0_mot", bus.motctl, 8'h20);
        strobe(1, 8'h02);
        step();
        chk("pri_src1_act", 8'(bus.active_src), 8'h01);
        chk("pri_src1_mot", bus.motctl, 8'h02);
        strobe(0, 8'h20);
        repeat (5) step();
        strobe(0, 8'h20);
        repeat (5) step();
        strobe(0, 8'h20);
        repeat (2) step();
        chk("pri_to_fresh", 8'(bus.src_fresh), 8'h01);
        chk("pri_to_still1", 8'(bus.active_src), 8'h01);
        step();
        chk("pri_back_act", 8'(bus.active_src), 8'h00);
        chk("pri_back_mot", bus.motctl, 8'h20);

        // Out-of-range manual selection.
        bus.mode = 1'b0;
        bus.sel_src = 2'd3;
        bus.src_cmd = 16'h0102;
        bus.src_valid = 2'b11;
        step();
        bus.src_valid = '0;
        repeat (2) step();
        chk("sel3_fs", 8'(bus.failsafe), 8'h01);
        chk("sel3_mot", bus.motctl, 8'h00);

        // Randomized traffic, alternating dense and sparse strobe phases.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) bus.mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                bus.sel_src = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            for (int i = 0; i < NSRC; i++) begin
                bus.src_valid[i] = ($urandom_range(0, ((cyc / 400) % 2 == 1) ? 24 : 4) == 0);
                bus.src_cmd[8*i +: 8] = 8'($urandom);
            end
            step();
        end
        bus.src_valid = '0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
